fwd_hazard_unit: RTL and testbench

// Parametrised forwarding and hazard controller for the RISC-V pipeline. It keeps a registered

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fwd_hazard_unit_if.sv | 29 ++
 rtl/fwd_port_match.sv | 41 ++++
 rtl/fwd_hazard_unit.sv | 85 ++++++++
 tb/tb_fwd_hazard_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the operand-forwarding logic: register address width,
// forwarding-select encoding and the layout of one in-flight destination entry.
package riscv_pkg;

  localparam int REG_AW = 5;

  // fwd_sel encoding: 0 selects the register file, k+1 selects stage k
  localparam int FWD_RF  = 0;
  localparam int FWD_EX  = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WB  = 3;

  localparam int SHADOW_EW = REG_AW + 3;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } shadow_ent_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and forwarding/stall response bundle of the hazard unit.
interface fwd_hazard_unit_if #(
  parameter int REG_AW = riscv_pkg::REG_AW,
  parameter int NPORTS = 2,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  logic                     id_valid;
  logic [NPORTS*REG_AW-1:0] id_rs;
  logic [NPORTS-1:0]        id_rs_used;
  logic [REG_AW-1:0]        id_rd;
  logic                     id_regwrite;
  logic                     id_is_load;
  logic                     stall_in;
  logic                     flush;
  logic [NPORTS*SEL_W-1:0]  fwd_sel;
  logic                     hazard_stall;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load, stall_in, flush,
    input  fwd_sel, hazard_stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load, stall_in, flush,
    output fwd_sel, hazard_stall, stall_cnt
  );
endinterface

// File: rtl/fwd_port_match.sv
// Priority search of the destination shadow for one ID read port; the youngest
// (lowest-stage) matching producer wins.
module fwd_port_match
  import riscv_pkg::*;
#(
  parameter int REG_AW   = riscv_pkg::REG_AW,
  parameter int NSTAGES  = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(NSTAGES + 1)
) (
  input  logic [REG_AW-1:0]              i_rs,
  input  logic                           i_used,
  input  logic                           i_valid,
  input  logic [NSTAGES-1:0]             i_v,
  input  logic [NSTAGES-1:0][REG_AW-1:0] i_rd,
  input  logic [NSTAGES-1:0]             i_wr,
  input  logic [NSTAGES-1:0]             i_ld,
  output logic [SEL_W-1:0]               o_sel,
  output logic                           o_load_hit
);

  logic [NSTAGES-1:0] w_hit;

  always_comb begin
    for (int k = 0; k < NSTAGES; k++)
      w_hit[k] = i_v[k] & i_wr[k] & (i_rd[k] != '0) & (i_rd[k] == i_rs) & i_used & i_valid;
  end

  // Walk oldest to youngest so the youngest hit overwrites the result last.
  always_comb begin
    o_sel      = SEL_W'(FWD_RF);
    o_load_hit = 1'b0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_sel      = SEL_W'(k + 1);
        o_load_hit = i_ld[k] & (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller: keeps a registered shadow of in-flight
// destinations, steers the ID operand muxes and raises/counts load-use stalls.
module fwd_hazard_unit
  import riscv_pkg::*;
#(
  parameter int REG_AW   = riscv_pkg::REG_AW,
  parameter int NPORTS   = 2,
  parameter int NSTAGES  = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = $clog2(NSTAGES + 1)
) (
  input logic               clk,
  input logic               reset,
  fwd_hazard_unit_if.slave  bus
);

  logic [NSTAGES-1:0]             r_v;
  logic [NSTAGES-1:0][REG_AW-1:0] r_rd;
  logic [NSTAGES-1:0]             r_wr;
  logic [NSTAGES-1:0]             r_ld;
  logic [CNT_W-1:0]               r_cnt;

  logic [NPORTS-1:0][SEL_W-1:0]   w_sel;
  logic [NPORTS-1:0]              w_load_hit;
  logic                           w_raw_stall;
  logic                           w_hazard;
  logic                           w_issue;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    fwd_port_match #(
      .REG_AW   (REG_AW),
      .NSTAGES  (NSTAGES),
      .LOAD_LAT (LOAD_LAT),
      .SEL_W    (SEL_W)
    ) u_match (
      .i_rs       (bus.id_rs[p*REG_AW +: REG_AW]),
      .i_used     (bus.id_rs_used[p]),
      .i_valid    (bus.id_valid),
      .i_v        (r_v),
      .i_rd       (r_rd),
      .i_wr       (r_wr),
      .i_ld       (r_ld),
      .o_sel      (w_sel[p]),
      .o_load_hit (w_load_hit[p])
    );
  end

  assign w_raw_stall = |w_load_hit;
  assign w_hazard    = w_raw_stall & ~bus.flush & ~bus.stall_in;
  // A stalled or flushed ID instruction enters EX as a bubble, which ages the load.
  assign w_issue     = bus.id_valid & ~bus.flush & ~w_hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v  <= '0;
      r_rd <= '0;
      r_wr <= '0;
      r_ld <= '0;
    end else if (!bus.stall_in) begin
      for (int k = NSTAGES - 1; k > 0; k--) begin
        r_v[k]  <= r_v[k-1];
        r_rd[k] <= r_rd[k-1];
        r_wr[k] <= r_wr[k-1];
        r_ld[k] <= r_ld[k-1];
      end
      r_v[0]  <= w_issue;
      r_rd[0] <= bus.id_rd;
      r_wr[0] <= bus.id_regwrite;
      r_ld[0] <= bus.id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (w_hazard && r_cnt != '1)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.fwd_sel      = w_sel;
  assign bus.hazard_stall = w_hazard;
  assign bus.stall_cnt    = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized scoreboard bench: a model tracks in-flight instructions by age and
// predicts forwarding, load-use stalls and stall counts for two counter widths.
module tb_fwd_hazard_unit;
  localparam int REG_AW   = 5;
  localparam int NPORTS   = 2;
  localparam int NSTAGES  = 3;
  localparam int LOAD_LAT = 1;
  localparam int CNT_W    = 16;
  localparam int CNT_W2   = 2;
  localparam int SEL_W    = $clog2(NSTAGES + 1);
  localparam int NCYC     = 3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                     d_valid = 1'b0;
  logic [NPORTS*REG_AW-1:0] d_rs = '0;
  logic [NPORTS-1:0]        d_used = '0;
  logic [REG_AW-1:0]        d_rd = '0;
  logic                     d_wr = 1'b0;
  logic                     d_ld = 1'b0;
  logic                     d_stall = 1'b0;
  logic                     d_flush = 1'b0;

  fwd_hazard_unit_if #(.REG_AW(REG_AW), .NPORTS(NPORTS), .SEL_W(SEL_W), .CNT_W(CNT_W))  bus();
  fwd_hazard_unit_if #(.REG_AW(REG_AW), .NPORTS(NPORTS), .SEL_W(SEL_W), .CNT_W(CNT_W2)) bus2();

  assign bus.id_valid = d_valid;   assign bus2.id_valid = d_valid;
  assign bus.id_rs = d_rs;         assign bus2.id_rs = d_rs;
  assign bus.id_rs_used = d_used;  assign bus2.id_rs_used = d_used;
  assign bus.id_rd = d_rd;         assign bus2.id_rd = d_rd;
  assign bus.id_regwrite = d_wr;   assign bus2.id_regwrite = d_wr;
  assign bus.id_is_load = d_ld;    assign bus2.id_is_load = d_ld;
  assign bus.stall_in = d_stall;   assign bus2.stall_in = d_stall;
  assign bus.flush = d_flush;      assign bus2.flush = d_flush;

  fwd_hazard_unit #(.REG_AW(REG_AW), .NPORTS(NPORTS), .NSTAGES(NSTAGES),
                    .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W), .SEL_W(SEL_W))
    dut (.clk(clk), .reset(reset), .bus(bus));

  fwd_hazard_unit #(.REG_AW(REG_AW), .NPORTS(NPORTS), .NSTAGES(NSTAGES),
                    .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W2), .SEL_W(SEL_W))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // Reference model: list of issued instructions with their age since issue.
  typedef struct {
    int              age;
    logic [REG_AW-1:0] rd;
    bit              wr;
    bit              ld;
  } inst_t;

  typedef struct {
    logic [NPORTS*SEL_W-1:0] sel;
    logic                    haz;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W2-1:0]       cnt2;
  } exp_t;

  inst_t  pipe[$];
  exp_t   sb[$];
  longint m_cnt  = 0;
  longint m_cnt2 = 0;
  int     checks = 0;
  int     errors = 0;

  function automatic exp_t model_out();
    exp_t e;
    bit   raw;
    raw   = 0;
    e.sel = '0;
    for (int p = 0; p < NPORTS; p++) begin
      int best;
      int best_age;
      logic [REG_AW-1:0] rs;
      rs = d_rs[p*REG_AW +: REG_AW];
      best = -1;
      best_age = 0;
      if (d_valid && d_used[p]) begin
        foreach (pipe[i]) begin
          if (pipe[i].wr && pipe[i].rd != 0 && pipe[i].rd == rs &&
              (best < 0 || pipe[i].age < best_age)) begin
            best = i;
            best_age = pipe[i].age;
          end
        end
      end
      if (best >= 0) begin
        e.sel[p*SEL_W +: SEL_W] = SEL_W'(best_age + 1);
        if (pipe[best].ld && best_age < LOAD_LAT) raw = 1;
      end
    end
    e.haz  = raw && !d_flush && !d_stall;
    e.cnt  = CNT_W'(m_cnt);
    e.cnt2 = CNT_W2'(m_cnt2);
    return e;
  endfunction

  // Advance the model across one clock edge using the inputs held during that cycle.
  task automatic model_step();
    exp_t  e;
    inst_t n;
    e = model_out();
    if (reset) begin
      pipe.delete();
      m_cnt  = 0;
      m_cnt2 = 0;
    end else begin
      if (e.haz) begin
        if (m_cnt  < (longint'(1) << CNT_W)  - 1) m_cnt++;
        if (m_cnt2 < (longint'(1) << CNT_W2) - 1) m_cnt2++;
      end
      if (!d_stall) begin
        for (int i = pipe.size() - 1; i >= 0; i--) begin
          pipe[i].age++;
          if (pipe[i].age >= NSTAGES) pipe.delete(i);
        end
        if (d_valid && !d_flush && !e.haz) begin
          n.age = 0; n.rd = d_rd; n.wr = d_wr; n.ld = d_ld;
          pipe.push_back(n);
        end
      end
    end
  endtask

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents its outputs every cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("fwd_sel", longint'(bus.fwd_sel), longint'(e.sel));
        check("hazard_stall", longint'(bus.hazard_stall), longint'(e.haz));
        check("stall_cnt", longint'(bus.stall_cnt), longint'(e.cnt));
        check("stall_cnt_w2", longint'(bus2.stall_cnt), longint'(e.cnt2));
      end
    end
  end

  initial begin
    bit hold;
    @(posedge clk);
    model_step();
    #1;
    sb.push_back(model_out());
    for (int c = 0; c < NCYC; c++) begin
      hold = model_out().haz;
      @(posedge clk);
      model_step();
      #1;
      reset   = (c < 2) || ($urandom_range(0, 99) < 2);
      d_stall = ($urandom_range(0, 99) < 12);
      d_flush = ($urandom_range(0, 99) < 8);
      // The pipeline holds the ID instruction while a load-use stall is raised.
      if (!hold) begin
        d_valid = ($urandom_range(0, 9) != 0);
        for (int p = 0; p < NPORTS; p++)
          d_rs[p*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
        d_used = NPORTS'($urandom_range(0, (1 << NPORTS) - 1)) | NPORTS'($urandom_range(0, 1));
        d_rd   = REG_AW'($urandom_range(0, 3));
        d_wr   = ($urandom_range(0, 9) < 8);
        d_ld   = ($urandom_range(0, 9) < 4);
      end
      sb.push_back(model_out());
    end
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", longint'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
